// File: rtl/cache_wb_pkg.sv
// rtl/cache_wb_pkg.sv - shared drain-state type and beat-count helper for the victim write-back buffer
package cache_wb_pkg;

  typedef enum logic {WB_IDLE, WB_XFER} wbstate_t;

  function automatic int beats(input int linelen, input int ahbw);
    return linelen / ahbw;
  endfunction

endpackage

// File: rtl/line_beat_mux.sv
// rtl/line_beat_mux.sv - selects one bus-width slice of a cache line by beat index
module line_beat_mux
  import cache_wb_pkg::*;
#(
  parameter int LINELEN = 512,
  parameter int AHBW    = 64,
  localparam int BEATS  = beats(LINELEN, AHBW),
  localparam int BEAT_W = $clog2(BEATS)
) (
  input  logic [LINELEN-1:0] line_i,
  input  logic [BEAT_W-1:0]  beat_i,
  output logic [AHBW-1:0]    data_o
);

  logic [AHBW-1:0] slice [BEATS];

  for (genvar g = 0; g < BEATS; g++) begin : g_slice
    assign slice[g] = line_i[g*AHBW +: AHBW];
  end

  assign data_o = slice[beat_i];

endmodule

// File: rtl/victim_wb_buffer.sv
// rtl/victim_wb_buffer.sv - dirty-victim FIFO that drains lines to the bus as ascending beat bursts
// and flags lookups that hit a line still awaiting write-back.
module victim_wb_buffer
  import cache_wb_pkg::*;
#(
  parameter int PA_BITS    = 56,
  parameter int LINELEN    = 512,
  parameter int AHBW       = 64,
  parameter int NUMENTRIES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               EvictValid,
  output logic               EvictReady,
  input  logic [PA_BITS-1:0] EvictAdr,
  input  logic [LINELEN-1:0] EvictLine,
  output logic               BusWValid,
  input  logic               BusWReady,
  output logic [PA_BITS-1:0] BusWAdr,
  output logic [AHBW-1:0]    BusWData,
  output logic               BusWFirst,
  output logic               BusWLast,
  input  logic [PA_BITS-1:0] LookupAdr,
  output logic               LookupHit,
  output logic               Empty
);

  localparam int BEATS    = beats(LINELEN, AHBW);
  localparam int BEAT_W   = $clog2(BEATS);
  localparam int OFF_BITS = $clog2(LINELEN / 8);
  localparam int BYTE_SH  = $clog2(AHBW / 8);
  localparam int LA_BITS  = PA_BITS - OFF_BITS;
  localparam int PTR_W    = (NUMENTRIES > 1) ? $clog2(NUMENTRIES) : 1;
  localparam int CNT_W    = $clog2(NUMENTRIES + 1);

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NUMENTRIES - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(NUMENTRIES);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  wbstate_t                  state_q, state_d;
  logic [PTR_W-1:0]          head_q, head_d;
  logic [PTR_W-1:0]          tail_q, tail_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [NUMENTRIES-1:0]     valid_q, valid_d;

  // Line storage is unreset; the valid bits alone say which slots mean anything.
  logic [LA_BITS-1:0]        adr_mem  [NUMENTRIES];
  logic [LINELEN-1:0]        line_mem [NUMENTRIES];

  logic push, beat_fire, pop;
  logic unused_offsets;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign EvictReady = (count_q != CNT_FULL);
  assign BusWValid  = (state_q == WB_XFER);
  assign push       = EvictValid & EvictReady;
  assign beat_fire  = BusWValid & BusWReady;
  assign pop        = beat_fire & (beat_q == BEAT_LAST);

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = next_ptr(head_q);
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = next_ptr(tail_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Decisions use count_d so a line pushed while idle, or alongside a final beat, starts next cycle.
    case (state_q)
      WB_IDLE: begin
        beat_d = '0;
        if (count_d != '0) state_d = WB_XFER;
      end
      WB_XFER: begin
        if (pop) begin
          beat_d = '0;
          if (count_d == '0) state_d = WB_IDLE;
        end else if (beat_fire) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= WB_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      beat_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      adr_mem[tail_q]  <= EvictAdr[PA_BITS-1:OFF_BITS];
      line_mem[tail_q] <= EvictLine;
    end
  end

  always_comb begin
    LookupHit = 1'b0;
    for (int i = 0; i < NUMENTRIES; i++) begin
      if (valid_q[i] && (adr_mem[i] == LookupAdr[PA_BITS-1:OFF_BITS])) LookupHit = 1'b1;
    end
  end

  // Lines are aligned, so beat offset concatenates rather than adds.
  assign BusWAdr   = {adr_mem[head_q], beat_q, {BYTE_SH{1'b0}}};
  assign BusWFirst = BusWValid & (beat_q == '0);
  assign BusWLast  = BusWValid & (beat_q == BEAT_LAST);
  assign Empty     = (count_q == '0) && (state_q == WB_IDLE);

  assign unused_offsets = ^{EvictAdr[OFF_BITS-1:0], LookupAdr[OFF_BITS-1:0]};

  line_beat_mux #(
    .LINELEN (LINELEN),
    .AHBW    (AHBW)
  ) u_beat_mux (
    .line_i (line_mem[head_q]),
    .beat_i (beat_q),
    .data_o (BusWData)
  );

endmodule
